exp_accel_param: RTL and testbench
==================================

Name: exp_accel_param

Overview:
- Parametrised successor of the single-shot exponential accelerator.
- Computes e^x for a fractional input x using an iterative Taylor-series engine with a configurable number of terms and configurable widths.
- Fed by an input FIFO, so several operands can be queued. Results leave through a held request/acknowledge write port.
- Sits between the operand producer and the memory-write interface in the lab datapath.

Parameters:
- TAG_W, 2: width of the pass-through tag `ui`; occupies the top bits of `wrData`.
- FRAC_W, 5: width of `vi`; x = vi / 2^FRAC_W, range [0, 1).
- INT_W, 2: integer bits of the result.
- OUT_FRAC_W, 17: fraction bits of the result and of all internal terms.
- TERMS, 5: Taylor terms, k = 0..TERMS-1. Legal range 2..16.
- DEPTH, 4: input FIFO entries. Power of two, at least 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- inValid  in  1  operand present on `ui`/`vi`.
- inReady  out  1  FIFO not full; push occurs when inValid && inReady.
- ui  in  TAG_W  tag, returned unchanged with the result.
- vi  in  FRAC_W  fractional operand.
- wrReq  out  1  result valid on `wrData`; held until acknowledged.
- wrAck  in  1  consumer accepts; transfer occurs when wrReq && wrAck.
- wrData  out  TAG_W+INT_W+OUT_FRAC_W  {tag, e^x as Q(INT_W).(OUT_FRAC_W)}.
- done  out  1  one-cycle pulse: last queued result accepted and block idle.
- busy  out  1  FIFO non-empty or FSM not in IDLE.

Behaviour:
- Reset: all outputs 0, except `inReady` = 1. FIFO emptied. FSM to IDLE.
- Reset mid-operation discards queued operands and any in-flight or pending result; no wrReq is emitted for them.

Input FIFO:
- Push on inValid && inReady.
- `inReady` = !full, registered from the occupancy count.
- Pop is made by the FSM in LOAD.
- Push and pop in the same cycle are both performed; count is unchanged.
- When full, inReady = 0 and `inValid` is ignored.
- Read/write pointers wrap modulo DEPTH.

FSM states: IDLE, LOAD, MULX, MULC, OUT.
- IDLE: if FIFO non-empty, go to LOAD.
- LOAD: pop the head entry; latch tag and x; term = sum = 1.0 (1 << OUT_FRAC_W); k = 1; go to MULX.
- MULX: term = (term * x) >> FRAC_W, truncating; go to MULC.
- MULC:
  - term = (term * R[k]) >> OUT_FRAC_W, truncating.
  - R[k] = floor(2^OUT_FRAC_W / k), constant table generated from the parameters.
  - sum += term.
  - If k == TERMS-1, go to OUT; else k++ and go to MULX.
- OUT:
  - wrReq = 1; wrData = {tag, sum}. Both held stable until wrAck.
  - On wrAck: if FIFO non-empty go to LOAD (no IDLE bubble); else go to IDLE and pulse `done`.

Timing:
- Latency from the cycle LOAD is entered to wrReq = 1 is 1 + 2*(TERMS-1) cycles: 9 with defaults.
- wrAck seen in the same cycle wrReq first rises is accepted.

Width and arithmetic rules:
- Product widths are full before the shift.
- sum is held at INT_W+OUT_FRAC_W bits.
- On carry out, sum saturates to all-ones.
- wrAck while wrReq = 0 is ignored.

Optional Feature:
- Macro: `EXP_ACCEL_PERF_CNT_EN`.
- When defined:
  - Adds output port `resultCount`, 16 bits.
  - The counter increments on each wrReq && wrAck and wraps 0xFFFF -> 0.
  - Cleared by rst.
  - Adds input port `cntClr`; clear has priority over a same-cycle increment.
- When undefined: neither port exists, no counter logic is present, and all other behaviour is identical.

Test Plan:
- Reset state: rst held 2 cycles -> wrReq = 0, done = 0, busy = 0, inReady = 1, wrData = 0.
- x = 0: push ui = 2, vi = 0; hold wrAck = 1 -> wrReq rises 9 cycles after LOAD; wrData = {2'b10, 19'h20000}; done pulses 1 cycle after the ack.
- x = 0.5 (defaults): push ui = 1, vi = 16 -> wrData = {2'b01, 19'h34BFF} (sum = 216063 ≈ 1.6484).
- Backpressure: push 3 operands, hold wrAck = 0 for 20 cycles ->
  - wrReq and wrData stay constant;
  - on acks, results come out in push order with tags intact;
  - done pulses once, only after the third ack.
- FIFO full: push DEPTH+1 operands while wrAck = 0 ->
  - inReady falls after DEPTH pushes;
  - the extra operand is not stored;
  - push and pop in the same cycle keep the count unchanged.
- Reset mid-computation: assert rst while in MULC with 2 operands queued -> no wrReq ever appears for them; busy = 0 after reset; with `EXP_ACCEL_PERF_CNT_EN`, resultCount = 0.

Source files
------------

// File: rtl/exp_accel_param.sv
`default_nettype none
// ============================================================================
//  Module   : exp_accel_param
//  Purpose  : FIFO-fed iterative Taylor-series e^x engine, x = vi / 2^FRAC_W,
//             with a held request/acknowledge result port.
//             Optional macro EXP_ACCEL_PERF_CNT_EN adds a result counter.
//  Revision : 1.0  initial release
// ============================================================================
module exp_accel_param #(
    parameter int TAG_W      = 2,
    parameter int FRAC_W     = 5,
    parameter int INT_W      = 2,
    parameter int OUT_FRAC_W = 17,
    parameter int TERMS      = 5,
    parameter int DEPTH      = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                inValid,
    output logic                                inReady,
    input  logic [TAG_W-1:0]                    ui,
    input  logic [FRAC_W-1:0]                   vi,
    output logic                                wrReq,
    input  logic                                wrAck,
    output logic [TAG_W+INT_W+OUT_FRAC_W-1:0]   wrData,
    output logic                                done,
    output logic                                busy
`ifdef EXP_ACCEL_PERF_CNT_EN
    ,
    output logic [15:0]                         resultCount,
    input  logic                                cntClr
`endif
);

    localparam int c_addr_w  = $clog2(DEPTH);
    localparam int c_k_w     = $clog2(TERMS);
    localparam int c_recip_n = 1 << c_k_w;
    localparam int c_term_w  = OUT_FRAC_W + 1;
    localparam int c_sum_w   = INT_W + OUT_FRAC_W;
    localparam int c_entry_w = TAG_W + FRAC_W;

    localparam logic [c_term_w-1:0] c_one_term = c_term_w'(1) << OUT_FRAC_W;
    localparam logic [c_sum_w-1:0]  c_one_sum  = c_sum_w'(1) << OUT_FRAC_W;
    localparam logic [c_addr_w:0]   c_full_cnt = (c_addr_w + 1)'(DEPTH);
    localparam logic [c_k_w-1:0]    c_last_k   = c_k_w'(TERMS - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_MULX = 3'd2,
        ST_MULC = 3'd3,
        ST_OUT  = 3'd4
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic                   r_done, w_done_nxt;

    logic [c_entry_w-1:0]   r_mem [DEPTH];
    logic [c_addr_w-1:0]    r_wr_ptr, r_rd_ptr;
    logic [c_addr_w:0]      r_count, w_count_nxt;
    logic                   r_in_ready;
    logic                   w_push, w_pop, w_empty;

    logic [TAG_W-1:0]       r_tag;
    logic [FRAC_W-1:0]      r_x;
    logic [c_term_w-1:0]    r_term;
    logic [c_sum_w-1:0]     r_sum;
    logic [c_k_w-1:0]       r_k;

    logic [c_term_w-1:0]          w_recip [c_recip_n];
    logic [c_term_w+FRAC_W-1:0]   w_px;
    logic [2*c_term_w-1:0]        w_pr;
    logic [c_term_w-1:0]          w_term_c;
    logic [c_sum_w:0]             w_sum_ext;
    logic                         w_unused_bits;

    // Reciprocal table R[k] = floor(2^OUT_FRAC_W / k); slots outside 1..TERMS-1 are never selected.
    for (genvar gi = 0; gi < c_recip_n; gi++) begin : g_recip
        if (gi == 0 || gi >= TERMS) begin : g_zero
            assign w_recip[gi] = '0;
        end else begin : g_val
            assign w_recip[gi] = c_term_w'((64'd1 << OUT_FRAC_W) / 64'(gi));
        end
    end

    // ---------------------------------------------------------------- FIFO
    assign w_push  = inValid && r_in_ready;
    assign w_pop   = (r_state == ST_LOAD);
    assign w_empty = (r_count == '0);

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {ui, vi};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_in_ready <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count    <= w_count_nxt;
            r_in_ready <= (w_count_nxt != c_full_cnt);
        end
    end

    // ----------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: if (!w_empty) w_state_nxt = ST_LOAD;
            ST_LOAD: w_state_nxt = ST_MULX;
            ST_MULX: w_state_nxt = ST_MULC;
            ST_MULC: w_state_nxt = (r_k == c_last_k) ? ST_OUT : ST_MULX;
            ST_OUT: begin
                if (wrAck) begin
                    if (!w_empty) begin
                        w_state_nxt = ST_LOAD;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------ datapath
    assign w_px      = {{FRAC_W{1'b0}}, r_term} * {{c_term_w{1'b0}}, r_x};
    assign w_pr      = {{c_term_w{1'b0}}, r_term} * {{c_term_w{1'b0}}, w_recip[r_k]};
    assign w_term_c  = w_pr[OUT_FRAC_W +: c_term_w];
    assign w_sum_ext = {1'b0, r_sum} + (c_sum_w + 1)'(w_term_c);
    // Truncated fraction bits; the top product bit is always zero since term and R[k] never exceed 1.0.
    assign w_unused_bits = ^{w_px[FRAC_W-1:0], w_pr[OUT_FRAC_W-1:0], w_pr[2*c_term_w-1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag  <= '0;
            r_x    <= '0;
            r_term <= '0;
            r_sum  <= '0;
            r_k    <= '0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    {r_tag, r_x} <= r_mem[r_rd_ptr];
                    r_term       <= c_one_term;
                    r_sum        <= c_one_sum;
                    r_k          <= c_k_w'(1);
                end
                ST_MULX: r_term <= w_px[FRAC_W +: c_term_w];
                ST_MULC: begin
                    r_term <= w_term_c;
                    r_sum  <= w_sum_ext[c_sum_w] ? '1 : w_sum_ext[c_sum_w-1:0];
                    if (r_k != c_last_k) r_k <= r_k + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign wrReq   = (r_state == ST_OUT);
    assign wrData  = wrReq ? {r_tag, r_sum} : '0;
    assign done    = r_done;
    assign busy    = !w_empty || (r_state != ST_IDLE);
    assign inReady = r_in_ready;

`ifdef EXP_ACCEL_PERF_CNT_EN
    logic [15:0] r_result_count;

    always_ff @(posedge clk) begin
        if (rst || cntClr) begin
            r_result_count <= '0;
        end else if (wrReq && wrAck) begin
            r_result_count <= r_result_count + 1'b1;
        end
    end

    assign resultCount = r_result_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_exp_accel_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_exp_accel_param
//  Purpose  : directed self-checking bench for exp_accel_param
//             (EXP_ACCEL_PERF_CNT_EN optional).
//  Revision : 1.0  initial release
// ============================================================================
module tb_exp_accel_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inValid = 1'b0;
    logic        wrAck = 1'b0;
    logic [1:0]  ui = '0;
    logic [4:0]  vi = '0;
    logic        inReady, wrReq, done, busy;
    logic [20:0] wrData;
`ifdef EXP_ACCEL_PERF_CNT_EN
    logic        cntClr = 1'b0;
    logic [15:0] resultCount;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int done_seen = 0;

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_seen++;

    exp_accel_param #(
        .TAG_W(2), .FRAC_W(5), .INT_W(2), .OUT_FRAC_W(17), .TERMS(5), .DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady),
        .ui(ui), .vi(vi), .wrReq(wrReq), .wrAck(wrAck), .wrData(wrData),
        .done(done), .busy(busy)
`ifdef EXP_ACCEL_PERF_CNT_EN
        , .resultCount(resultCount), .cntClr(cntClr)
`endif
    );

    // Hand-computed Taylor sums (5 terms, truncating) for the operands used here.
    function automatic logic [20:0] exp_word(input logic [1:0] t, input logic [4:0] v);
        logic [18:0] s;
        case (v)
            5'd0:    s = 19'h20000;
            5'd8:    s = 19'h2916A;
            5'd16:   s = 19'h34BFF;
            default: s = '0;
        endcase
        return {t, s};
    endfunction

    task automatic wait_req(input string name);
        int n = 0;
        while (wrReq !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        n_cmp++;
        if (wrReq !== 1'b1) begin $display("FAIL %s timeout: wrReq=%b want 1", name, wrReq); n_err++; end
    endtask

    task automatic test_reset();
        rst = 1'b1; inValid = 1'b0; wrAck = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (wrReq !== 1'b0)    begin $display("FAIL reset_wrReq: got %b want 0", wrReq); n_err++; end
        n_cmp++; if (done !== 1'b0)     begin $display("FAIL reset_done: got %b want 0", done); n_err++; end
        n_cmp++; if (busy !== 1'b0)     begin $display("FAIL reset_busy: got %b want 0", busy); n_err++; end
        n_cmp++; if (inReady !== 1'b1)  begin $display("FAIL reset_inReady: got %b want 1", inReady); n_err++; end
        n_cmp++; if (wrData !== 21'h0)  begin $display("FAIL reset_wrData: got %h want 0", wrData); n_err++; end
`ifdef EXP_ACCEL_PERF_CNT_EN
        n_cmp++; if (resultCount !== 16'h0) begin $display("FAIL reset_count: got %h want 0", resultCount); n_err++; end
`endif
        rst = 1'b0;
    endtask

    task automatic test_x_zero();
        int n;
        @(negedge clk);
        ui = 2'd2; vi = 5'd0; inValid = 1'b1; wrAck = 1'b1;
        @(negedge clk);
        inValid = 1'b0;
        n = 1;
        while (wrReq !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        // LOAD is seen at n = 2, so OUT nine cycles later is n = 11
        n_cmp++; if (n != 11) begin $display("FAIL x0_latency: got %0d want 11", n); n_err++; end
        n_cmp++; if (wrData !== {2'b10, 19'h20000}) begin $display("FAIL x0_data: got %h want %h", wrData, {2'b10, 19'h20000}); n_err++; end
        n_cmp++; if (done !== 1'b0) begin $display("FAIL x0_done_early: got %b want 0", done); n_err++; end
        @(negedge clk);
        n_cmp++; if (done !== 1'b1) begin $display("FAIL x0_done_pulse: got %b want 1", done); n_err++; end
        n_cmp++; if (wrReq !== 1'b0) begin $display("FAIL x0_req_drop: got %b want 0", wrReq); n_err++; end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0) begin $display("FAIL x0_done_width: got %b want 0", done); n_err++; end
        n_cmp++; if (busy !== 1'b0) begin $display("FAIL x0_busy_idle: got %b want 0", busy); n_err++; end
        wrAck = 1'b0;
    endtask

    task automatic test_x_half();
        @(negedge clk);
        ui = 2'd1; vi = 5'd16; inValid = 1'b1; wrAck = 1'b1;
        @(negedge clk);
        inValid = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin $display("FAIL xh_busy: got %b want 1", busy); n_err++; end
        wait_req("xh_req");
        n_cmp++; if (wrData !== exp_word(2'd1, 5'd16)) begin $display("FAIL xh_data: got %h want %h", wrData, exp_word(2'd1, 5'd16)); n_err++; end
        @(negedge clk);
        n_cmp++; if (done !== 1'b1) begin $display("FAIL xh_done: got %b want 1", done); n_err++; end
        wrAck = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [20:0] expv [3];
        int d0;
        expv[0] = exp_word(2'd3, 5'd0);
        expv[1] = exp_word(2'd0, 5'd16);
        expv[2] = exp_word(2'd1, 5'd8);
        wrAck = 1'b0;
        @(negedge clk); #1; d0 = done_seen;
        ui = 2'd3; vi = 5'd0;  inValid = 1'b1;
        @(negedge clk); ui = 2'd0; vi = 5'd16;
        @(negedge clk); ui = 2'd1; vi = 5'd8;
        @(negedge clk); inValid = 1'b0;
        wait_req("bp_first_req");
        repeat (20) begin
            @(negedge clk);
            n_cmp++; if (wrReq !== 1'b1 || wrData !== expv[0]) begin
                $display("FAIL bp_hold: req=%b data=%h want req=1 data=%h", wrReq, wrData, expv[0]); n_err++;
            end
        end
        for (int r = 0; r < 3; r++) begin
            wait_req("bp_req");
            n_cmp++; if (wrData !== expv[r]) begin $display("FAIL bp_order%0d: got %h want %h", r, wrData, expv[r]); n_err++; end
            wrAck = 1'b1;
            @(negedge clk);
            wrAck = 1'b0;
            n_cmp++; if (done !== (r == 2)) begin $display("FAIL bp_done%0d: got %b want %b", r, done, (r == 2)); n_err++; end
        end
        @(negedge clk); #1;
        n_cmp++; if (done_seen - d0 != 1) begin $display("FAIL bp_done_count: got %0d want 1", done_seen - d0); n_err++; end
    endtask

    task automatic test_fifo_full();
        logic [1:0] tg [8];
        logic [4:0] vv [8];
        int order [5];
        logic seen;
        tg = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        vv = '{5'd0, 5'd16, 5'd8, 5'd0, 5'd16, 5'd8, 5'd0, 5'd8};
        order = '{2, 3, 4, 6, 7};
        wrAck = 1'b0;
        @(negedge clk);
        ui = tg[0]; vi = vv[0]; inValid = 1'b1;
        @(negedge clk);
        inValid = 1'b0;
        wait_req("ff_stall_req");
        // B..E fill the FIFO; F is offered while full and must be dropped
        for (int i = 1; i <= 5; i++) begin
            ui = tg[i]; vi = vv[i]; inValid = 1'b1;
            @(negedge clk);
            n_cmp++; if (inReady !== (i < 4)) begin $display("FAIL ff_inReady%0d: got %b want %b", i, inReady, (i < 4)); n_err++; end
        end
        inValid = 1'b0;
        n_cmp++; if (wrData !== exp_word(tg[0], vv[0])) begin $display("FAIL ff_dataA: got %h want %h", wrData, exp_word(tg[0], vv[0])); n_err++; end
        wrAck = 1'b1;
        @(negedge clk);
        wrAck = 1'b0;
        n_cmp++; if (inReady !== 1'b0) begin $display("FAIL ff_still_full: got %b want 0", inReady); n_err++; end
        @(negedge clk);
        n_cmp++; if (inReady !== 1'b1) begin $display("FAIL ff_after_pop: got %b want 1", inReady); n_err++; end
        wait_req("ff_reqB");
        n_cmp++; if (wrData !== exp_word(tg[1], vv[1])) begin $display("FAIL ff_dataB: got %h want %h", wrData, exp_word(tg[1], vv[1])); n_err++; end
        wrAck = 1'b1;
        @(negedge clk);
        wrAck = 1'b0;
        ui = tg[6]; vi = vv[6]; inValid = 1'b1;   // lands on the LOAD pop cycle
        @(negedge clk);
        n_cmp++; if (inReady !== 1'b1) begin $display("FAIL ff_push_pop: got %b want 1", inReady); n_err++; end
        ui = tg[7]; vi = vv[7];
        @(negedge clk);
        inValid = 1'b0;
        n_cmp++; if (inReady !== 1'b0) begin $display("FAIL ff_refull: got %b want 0", inReady); n_err++; end
        wrAck = 1'b1;
        for (int j = 0; j < 5; j++) begin
            wait_req("ff_drain_req");
            n_cmp++; if (wrData !== exp_word(tg[order[j]], vv[order[j]])) begin
                $display("FAIL ff_drain%0d: got %h want %h", j, wrData, exp_word(tg[order[j]], vv[order[j]])); n_err++;
            end
            @(negedge clk);
        end
        n_cmp++; if (done !== 1'b1) begin $display("FAIL ff_done: got %b want 1", done); n_err++; end
        seen = 1'b0;
        repeat (15) begin @(negedge clk); if (wrReq === 1'b1) seen = 1'b1; end
        n_cmp++; if (seen !== 1'b0) begin $display("FAIL ff_dropped_emitted: got %b want 0", seen); n_err++; end
        n_cmp++; if (busy !== 1'b0) begin $display("FAIL ff_busy_end: got %b want 0", busy); n_err++; end
        wrAck = 1'b0;
    endtask

`ifdef EXP_ACCEL_PERF_CNT_EN
    task automatic test_perf_counter();
        @(negedge clk);
        n_cmp++; if (resultCount !== 16'd12) begin $display("FAIL perf_total: got %0d want 12", resultCount); n_err++; end
        ui = 2'd2; vi = 5'd8; inValid = 1'b1;
        @(negedge clk);
        inValid = 1'b0;
        wait_req("perf_req");
        wrAck = 1'b1; cntClr = 1'b1;
        @(negedge clk);
        wrAck = 1'b0; cntClr = 1'b0;
        n_cmp++; if (resultCount !== 16'd0) begin $display("FAIL perf_clr_priority: got %0d want 0", resultCount); n_err++; end
        ui = 2'd1; vi = 5'd0; inValid = 1'b1;
        @(negedge clk);
        inValid = 1'b0;
        wait_req("perf_req2");
        wrAck = 1'b1;
        @(negedge clk);
        wrAck = 1'b0;
        n_cmp++; if (resultCount !== 16'd1) begin $display("FAIL perf_incr: got %0d want 1", resultCount); n_err++; end
        repeat (2) @(negedge clk);
    endtask
`endif

    task automatic test_reset_mid();
        logic seen;
        wrAck = 1'b0;
        @(negedge clk); ui = 2'd1; vi = 5'd16; inValid = 1'b1;
        @(negedge clk); ui = 2'd2; vi = 5'd8;
        @(negedge clk); ui = 2'd3; vi = 5'd0;
        @(negedge clk); inValid = 1'b0;
        @(negedge clk);                            // engine in MULC, two queued
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (busy !== 1'b0)    begin $display("FAIL rm_busy: got %b want 0", busy); n_err++; end
        n_cmp++; if (wrReq !== 1'b0)   begin $display("FAIL rm_wrReq: got %b want 0", wrReq); n_err++; end
        n_cmp++; if (inReady !== 1'b1) begin $display("FAIL rm_inReady: got %b want 1", inReady); n_err++; end
`ifdef EXP_ACCEL_PERF_CNT_EN
        n_cmp++; if (resultCount !== 16'd0) begin $display("FAIL rm_count: got %0d want 0", resultCount); n_err++; end
`endif
        wrAck = 1'b1;
        seen = 1'b0;
        repeat (30) begin @(negedge clk); if (wrReq === 1'b1) seen = 1'b1; end
        n_cmp++; if (seen !== 1'b0) begin $display("FAIL rm_no_result: got %b want 0", seen); n_err++; end
        wrAck = 1'b0;
    endtask

    initial begin
        test_reset();
        test_x_zero();
        test_x_half();
        test_backpressure();
        test_fifo_full();
`ifdef EXP_ACCEL_PERF_CNT_EN
        test_perf_counter();
`endif
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
